fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the 8x16 FIFO block.

---
 rtl/fifo_sync_param.sv | 116 +++++++++++
 tb/tb_fifo_sync_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with a registered fill level, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow, a synchronous
// flush and a choice of standard or first-word-fall-through read.
module fifo_sync_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter bit FWFT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   level_q;
  logic              we;
  logic              re;

  // Status flags decode straight from the registered level.
  assign level        = level_q;
  assign full         = (level_q == DEPTH_V);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);

  // Flush masks both requests; full/empty gate them from the current level.
  assign we = wr & ~full & ~clr;
  assign re = rd & ~empty & ~clr;

  // Storage array; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wptr[ADDR_W-1:0]] <= data_in;
  end

  // Pointers and fill level; pointers carry one extra bit and wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else if (clr) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
      case ({we, re})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky error flags; only flush or reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full)  overflow  <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented continuously; valid whenever something is stored.
      assign data_out = mem[rptr[ADDR_W-1:0]];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              rvld_q;

      // Registered read port: data lands one edge after the accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
          rvld_q <= 1'b0;
        end else if (clr) begin
          rvld_q <= 1'b0;
        end else begin
          rvld_q <= re;
          if (re) dout_q <= mem[rptr[ADDR_W-1:0]];
        end
      end

      assign data_out = dout_q;
      assign rd_valid = rvld_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a standard-read and an FWFT instance share all
// inputs; a vector table drives the main sequences, hand sequences cover
// FWFT head visibility and asynchronous reset mid-burst.
module tb_fifo_sync_param;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr;
  logic [7:0] data_in;
  logic       rd;
  logic [4:0] af_thresh;
  logic [4:0] ae_thresh;

  logic [7:0] s_dout, f_dout;
  logic       s_rv, f_rv;
  logic       s_full, f_full, s_empty, f_empty;
  logic       s_af, f_af, s_ae, f_ae;
  logic [4:0] s_level, f_level;
  logic       s_ovf, f_ovf, s_udf, f_udf;

  int n_chk;
  int n_fail;

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .data_in(data_in), .rd(rd),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .data_out(s_dout), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
    .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1'b1)) u_fw (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .data_in(data_in), .rd(rd),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .data_out(f_dout), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] din;
    logic [4:0] af;
    logic [4:0] ae;
    logic [4:0] lvl;
    logic       ovf;
    logic       udf;
    logic       rv;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic w, input logic r, input logic c,
                              input logic [7:0] d, input logic [4:0] af,
                              input logic [4:0] ae, input logic [4:0] lvl,
                              input logic ovf, input logic udf, input logic rv,
                              input logic [7:0] dout);
    vec_t v;
    v.wr = w; v.rd = r; v.clr = c; v.din = d; v.af = af; v.ae = ae;
    v.lvl = lvl; v.ovf = ovf; v.udf = udf; v.rv = rv; v.dout = dout;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; data_in = 8'h00;
    af_thresh = 5'd0; ae_thresh = 5'd3;

    // Reset state
    #12;
    chk("rst_level", 32'(s_level), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full", 32'(s_full), 32'd0);
    chk("rst_ovf", 32'(s_ovf), 32'd0);
    chk("rst_udf", 32'(s_udf), 32'd0);
    chk("rst_rv", 32'(s_rv), 32'd0);
    chk("rst_dout", 32'(s_dout), 32'd0);
    chk("rst_af_thr0", 32'(s_af), 32'd1);
    chk("rst_ae", 32'(s_ae), 32'd1);
    chk("rst_fw_rv", 32'(f_rv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then overflow attempt
    for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(i), 12, 3, 5'(i + 1), 0, 0, 0, 8'h00);
    add(1, 0, 0, 8'hAA, 12, 3, 16, 1, 0, 0, 8'h00);
    // Drain in order, then underflow attempt
    for (int i = 0; i < 16; i++) add(0, 1, 0, 8'h00, 12, 3, 5'(15 - i), 1, 0, 1, 8'(i));
    add(0, 1, 0, 8'h00, 12, 3, 0, 1, 1, 0, 8'h0F);
    add(0, 0, 0, 8'h00, 0, 3, 0, 1, 1, 0, 8'h0F);
    add(0, 0, 1, 8'h00, 12, 3, 0, 0, 0, 0, 8'h0F);
    // Wrap: write 10, read 10, write 16, read 16
    for (int i = 0; i < 10; i++) add(1, 0, 0, 8'(8'h20 + i), 12, 3, 5'(i + 1), 0, 0, 0, 8'h0F);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 8'h00, 12, 3, 5'(9 - i), 0, 0, 1, 8'(8'h20 + i));
    for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(8'h40 + i), 12, 3, 5'(i + 1), 0, 0, 0, 8'h29);
    add(0, 0, 0, 8'h00, 0, 16, 16, 0, 0, 0, 8'h29);
    add(0, 0, 0, 8'h00, 16, 15, 16, 0, 0, 0, 8'h29);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 8'h00, 12, 3, 5'(15 - i), 0, 0, 1, 8'(8'h40 + i));
    // Simultaneous read/write at mid level, full and empty
    for (int i = 0; i < 5; i++) add(1, 0, 0, 8'(8'h60 + i), 12, 3, 5'(i + 1), 0, 0, 0, 8'h4F);
    add(1, 1, 0, 8'h70, 12, 3, 5, 0, 0, 1, 8'h60);
    for (int i = 0; i < 11; i++) add(1, 0, 0, 8'(8'h71 + i), 12, 3, 5'(6 + i), 0, 0, 0, 8'h60);
    add(1, 1, 0, 8'hEE, 12, 3, 15, 1, 0, 1, 8'h61);
    add(0, 0, 1, 8'h00, 12, 3, 0, 0, 0, 0, 8'h61);
    add(1, 1, 0, 8'h90, 12, 3, 1, 0, 1, 0, 8'h61);
    add(0, 1, 0, 8'h00, 12, 3, 0, 0, 1, 1, 8'h90);
    // Thresholds af=12 ae=3, then flush at level 9
    add(0, 0, 1, 8'h00, 12, 3, 0, 0, 0, 0, 8'h90);
    for (int i = 0; i < 12; i++) add(1, 0, 0, 8'(8'hB0 + i), 12, 3, 5'(i + 1), 0, 0, 0, 8'h90);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 8'h00, 12, 3, 5'(11 - i), 0, 0, 1, 8'(8'hB0 + i));
    add(1, 1, 1, 8'hFF, 12, 3, 0, 0, 0, 0, 8'hB2);

    foreach (vecs[k]) begin
      wr = vecs[k].wr; rd = vecs[k].rd; clr = vecs[k].clr; data_in = vecs[k].din;
      af_thresh = vecs[k].af; ae_thresh = vecs[k].ae;
      step();
      chk($sformatf("v%0d_level", k), 32'(s_level), 32'(vecs[k].lvl));
      chk($sformatf("v%0d_full", k), 32'(s_full), 32'(vecs[k].lvl == 5'd16));
      chk($sformatf("v%0d_empty", k), 32'(s_empty), 32'(vecs[k].lvl == 5'd0));
      chk($sformatf("v%0d_afull", k), 32'(s_af), 32'(vecs[k].lvl >= vecs[k].af));
      chk($sformatf("v%0d_aempty", k), 32'(s_ae), 32'(vecs[k].lvl <= vecs[k].ae));
      chk($sformatf("v%0d_ovf", k), 32'(s_ovf), 32'(vecs[k].ovf));
      chk($sformatf("v%0d_udf", k), 32'(s_udf), 32'(vecs[k].udf));
      chk($sformatf("v%0d_rv", k), 32'(s_rv), 32'(vecs[k].rv));
      chk($sformatf("v%0d_dout", k), 32'(s_dout), 32'(vecs[k].dout));
      chk($sformatf("v%0d_fw_rv", k), 32'(f_rv), 32'(vecs[k].lvl != 5'd0));
    end
    idle();
    af_thresh = 5'd12; ae_thresh = 5'd3;

    // FWFT: word written into empty FIFO is visible one edge later without rd
    wr = 1'b1; data_in = 8'hC5; step();
    wr = 1'b0;
    chk("fw_first_rv", 32'(f_rv), 32'd1);
    chk("fw_first_head", 32'(f_dout), 32'hC5);
    wr = 1'b1; data_in = 8'hC6; step();
    wr = 1'b0;
    chk("fw_head_kept", 32'(f_dout), 32'hC5);
    rd = 1'b1; step();
    chk("fw_pop_head", 32'(f_dout), 32'hC6);
    chk("fw_pop_rv", 32'(f_rv), 32'd1);
    step();
    rd = 1'b0;
    chk("fw_drained_rv", 32'(f_rv), 32'd0);
    chk("fw_drained_lvl", 32'(f_level), 32'd0);

    // FWFT full fill across the pointer wrap, read back in order
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; data_in = 8'(8'hD0 + i); step();
    end
    wr = 1'b0;
    chk("fw_full", 32'(f_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fw_wrap_head%0d", i), 32'(f_dout), 32'(8'hD0 + i));
      chk($sformatf("fw_wrap_rv%0d", i), 32'(f_rv), 32'd1);
      rd = 1'b1; step();
    end
    rd = 1'b0;
    chk("fw_wrap_empty", 32'(f_empty), 32'd1);

    // Asynchronous reset in the middle of a write burst with a read pending
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; data_in = 8'(8'hE0 + i); step();
    end
    rd = 1'b1; step();
    chk("pre_rst_dout", 32'(s_dout), 32'hE0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(s_level), 32'd0);
    chk("arst_empty", 32'(s_empty), 32'd1);
    chk("arst_dout", 32'(s_dout), 32'd0);
    chk("arst_rv", 32'(s_rv), 32'd0);
    chk("arst_afull", 32'(s_af), 32'd0);
    chk("arst_aempty", 32'(s_ae), 32'd1);
    chk("arst_fw_rv", 32'(f_rv), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_level", 32'(s_level), 32'd0);
    chk("post_rst_ovf", 32'(s_ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
